actuator_pwm_driver: RTL and testbench

Output stage placed directly downstream of the PID controller. It converts the signed 16-bit control word `u_out` into a slew-limited, saturated PWM waveform plus a direction bit for an H-bridge. It also generates the period timebase the system uses to pace control updates.

---
 rtl/actuator_pwm_driver.sv | 75 +++++++
 tb/tb_actuator_pwm_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/actuator_pwm_driver.sv
// actuator_pwm_driver: saturated PWM plus H-bridge direction from a signed command, with the period timebase.
// Macro ACT_SLEW_EN enables slew limiting, ramp-down before reversal and the DRAIN state.
module actuator_pwm_driver #(
  parameter int PERIOD   = 1000,
  parameter int MAX_STEP = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] u_in,
  input  logic        u_valid,
  output logic        pwm_out,
  output logic        dir,
  output logic [15:0] duty,
  output logic        sat_flag,
  output logic        period_start,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
`ifdef ACT_SLEW_EN
  localparam bit SLEW = 1'b1;
  localparam logic [15:0] STEP = 16'(MAX_STEP < PERIOD ? MAX_STEP : PERIOD);
`else
  // a step no smaller than the full period turns the ramp into a direct jump
  localparam bit SLEW = 1'b0;
  localparam logic [15:0] STEP = 16'(MAX_STEP > PERIOD && MAX_STEP < 32768 ? MAX_STEP : PERIOD);
`endif
  localparam logic [15:0] P16  = 16'(PERIOD);
  localparam logic [15:0] LAST = 16'(PERIOD - 1);
  state_t state, state_nxt;
  logic [15:0] cnt, shadow, tgt, dn, up, duty_nxt;
  logic [16:0] mag;
  logic upd, same, ramp, dir_nxt, sat_nxt;
  always_comb begin
    upd = (state == IDLE) ? enable : (cnt == LAST);
    mag = shadow[15] ? 17'd0 - {1'b1, shadow} : {1'b0, shadow};
    sat_nxt = enable && (mag > {1'b0, P16});
    tgt = !enable ? 16'd0 : sat_nxt ? P16 : mag[15:0];
    same = (tgt == 16'd0) || (shadow[15] == dir);
    ramp = SLEW && (duty != 16'd0);
    dn = (duty > STEP) ? duty - STEP : 16'd0;
    up = duty + STEP;
    duty_nxt = !same ? (ramp ? dn : (tgt < STEP ? tgt : STEP))
             : (duty > tgt) ? (dn > tgt ? dn : tgt) : (up < tgt ? up : tgt);
    dir_nxt = (!same && !ramp) ? shadow[15] : dir;
    state_nxt = (state == IDLE) ? (enable ? RUN : IDLE)
              : !upd ? state
              : enable ? RUN
              : (SLEW && (state == RUN || duty != 16'd0)) ? DRAIN : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shadow       <= '0;
      duty         <= '0;
      dir          <= 1'b0;
      sat_flag     <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= (state == IDLE || cnt == LAST) ? 16'd0 : cnt + 16'd1;
      shadow       <= u_valid ? u_in : shadow;
      pwm_out      <= (state_nxt != IDLE) && (cnt < duty);
      period_start <= upd && (state_nxt != IDLE);
      if (upd) begin
        duty     <= duty_nxt;
        dir      <= dir_nxt;
        sat_flag <= sat_nxt;
      end
    end
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_actuator_pwm_driver.sv
// tb_actuator_pwm_driver: directed checks of ramp, saturation, reversal, drain and reset with PERIOD=100, MAX_STEP=20.
module tb_actuator_pwm_driver;
  localparam int PERIOD   = 100;
  localparam int MAX_STEP = 20;
`ifdef ACT_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, u_valid = 1'b0;
  logic [15:0] u_in = '0;
  logic pwm_out, dir, sat_flag, period_start, busy;
  logic [15:0] duty;
  int n_chk = 0, n_fail = 0, hi = 0;

  actuator_pwm_driver #(.PERIOD(PERIOD), .MAX_STEP(MAX_STEP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .u_in(u_in), .u_valid(u_valid),
    .pwm_out(pwm_out), .dir(dir), .duty(duty), .sat_flag(sat_flag),
    .period_start(period_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_upd(input string tag, input int d, input int dr, input int s);
    check({tag, ".ps"}, int'(period_start), 1);
    check({tag, ".busy"}, int'(busy), 1);
    check({tag, ".duty"}, int'(duty), d);
    check({tag, ".dir"}, int'(dir), dr);
    check({tag, ".sat"}, int'(sat_flag), s);
  endtask

  task automatic load(input logic [15:0] u);
    u_in = u;
    u_valid = 1'b1;
  endtask

  task automatic next_period;
    hi = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      u_valid = 1'b0;
      hi += int'(pwm_out);
    end
  endtask

  task automatic expect_period(input string tag, input int d, input int dr, input int s);
    next_period;
    check_upd(tag, d, dr, s);
  endtask

  task automatic restart(input string tag, input logic [15:0] u, input int d, input int dr, input int s);
    rst = 1'b1;
    enable = 1'b0;
    u_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    load(u);
    @(negedge clk);
    u_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check_upd(tag, d, dr, s);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset.pwm", int'(pwm_out), 0);
    check("reset.dir", int'(dir), 0);
    check("reset.duty", int'(duty), 0);
    check("reset.sat", int'(sat_flag), 0);
    check("reset.ps", int'(period_start), 0);
    check("reset.busy", int'(busy), 0);

    restart("sat1", 16'd1000, SLEW ? 20 : 100, 0, 1);
    expect_period("sat2", SLEW ? 40 : 100, 0, 1);
    check("sat2.hi", hi, SLEW ? 20 : 100);
    expect_period("sat3", SLEW ? 60 : 100, 0, 1);
    expect_period("sat4", SLEW ? 80 : 100, 0, 1);
    expect_period("sat5", 100, 0, 1);
    expect_period("sat6", 100, 0, 1);
    check("sat6.hi", hi, 100);

    restart("small1", 16'd50, SLEW ? 20 : 50, 0, 0);
    expect_period("small2", SLEW ? 40 : 50, 0, 0);
    expect_period("small3", 50, 0, 0);
    expect_period("small4", 50, 0, 0);
    check("small4.hi", hi, 50);
    repeat (50) @(negedge clk);
    check("small.cnt49", int'(pwm_out), 1);
    @(negedge clk);
    check("small.cnt50", int'(pwm_out), 0);
    repeat (PERIOD - 51) @(negedge clk);
    check("small5.ps", int'(period_start), 1);

    restart("rev1", 16'd60, SLEW ? 20 : 60, 0, 0);
    expect_period("rev2", SLEW ? 40 : 60, 0, 0);
    expect_period("rev3", 60, 0, 0);
    load(16'hFE0C);
`ifdef ACT_SLEW_EN
    expect_period("rev4", 40, 0, 1);
    expect_period("rev5", 20, 0, 1);
    expect_period("rev6", 0, 0, 1);
    expect_period("rev7", 20, 1, 1);
    expect_period("rev8", 40, 1, 1);
    expect_period("rev9", 60, 1, 1);
    expect_period("rev10", 80, 1, 1);
    expect_period("rev11", 100, 1, 1);
`else
    expect_period("rev4", 100, 1, 1);
`endif
    load(16'd0);
    expect_period("hold0", SLEW ? 80 : 0, 1, 0);

    restart("neg1", 16'h8000, SLEW ? 20 : 100, 1, 1);
    expect_period("neg2", SLEW ? 40 : 100, 1, 1);
    expect_period("neg3", SLEW ? 60 : 100, 1, 1);
    expect_period("neg4", SLEW ? 80 : 100, 1, 1);
    expect_period("neg5", 100, 1, 1);

    restart("drn1", 16'd60, SLEW ? 20 : 60, 0, 0);
    expect_period("drn2", SLEW ? 40 : 60, 0, 0);
    expect_period("drn3", 60, 0, 0);
    enable = 1'b0;
`ifdef ACT_SLEW_EN
    expect_period("drn4", 40, 0, 0);
    check("drn4.hi", hi, 60);
    expect_period("drn5", 20, 0, 0);
    expect_period("drn6", 0, 0, 0);
`endif
    next_period;
    check("drn_end.ps", int'(period_start), 0);
    check("drn_end.busy", int'(busy), 0);
    check("drn_end.duty", int'(duty), 0);
    repeat (5) @(negedge clk);
    check("idle.pwm", int'(pwm_out), 0);
    check("idle.busy", int'(busy), 0);

    restart("rst1", 16'hFFB0, SLEW ? 20 : 80, 1, 0);
`ifdef ACT_SLEW_EN
    expect_period("rst2", 40, 1, 0);
    expect_period("rst3", 60, 1, 0);
    expect_period("rst4", 80, 1, 0);
`endif
    repeat (30) @(negedge clk);
    check("rst.pre_pwm", int'(pwm_out), 1);
    #2 rst = 1'b1;
    #1;
    check("rst.pwm", int'(pwm_out), 0);
    check("rst.duty", int'(duty), 0);
    check("rst.dir", int'(dir), 0);
    check("rst.busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_upd("rst_rel", 0, 0, 0);
    expect_period("rst_run", 0, 0, 0);
    check("rst_run.hi", hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
